alu_ffec32: RTL and testbench

ALU_FFEC32 -- requirements
Module: alu_ffec32

---
 rtl/alu_ffec32.sv | 82 ++++++++
 tb/tb_alu_ffec32.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_ffec32.sv
// alu_ffec32 -- combinational four-function ALU feeding a loadable register.
//
// The ALU computes R from X and Y with no latency. Z is high exactly when R is
// zero. The register Q loads either R or the external data D on a rising clock
// edge when En is high. Qn is always the bitwise complement of Q.
//
// Ports:
//   Clk   in   1      rising-edge clock for the register
//   Clrn  in   1      asynchronous active-low clear of the register
//   X     in   WIDTH  ALU operand A
//   Y     in   WIDTH  ALU operand B
//   Aluc  in   2      ALU operation: 00 add, 01 subtract, 10 and, 11 or
//   D     in   WIDTH  external register load data
//   Sel   in   1      register source: 0 = R, 1 = D
//   En    in   1      register load enable
//   R     out  WIDTH  ALU result (combinational)
//   Z     out  1      zero flag of R (combinational)
//   Q     out  WIDTH  registered value
//   Qn    out  WIDTH  complement of Q
module alu_ffec32 #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [1:0]       Aluc,
  input  logic [WIDTH-1:0] D,
  input  logic             Sel,
  input  logic             En,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Add and subtract are kept to WIDTH bits, so the carry/borrow is dropped
  // and results wrap modulo 2^WIDTH.
  always_comb begin
    r_d = '0;
    case (Aluc)
      OP_ADD:  r_d = X + Y;
      OP_SUB:  r_d = X - Y;
      OP_AND:  r_d = X & Y;
      OP_OR:   r_d = X | Y;
      default: r_d = '0;
    endcase
  end

  // Next register value: load from D or the current ALU result, else hold.
  always_comb begin
    q_d = q_q;
    if (En) begin
      q_d = Sel ? D : r_d;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign R  = r_d;
  assign Z  = (r_d == '0);
  assign Q  = q_q;
  // Derived from the flop rather than stored separately, so Qn tracks Q
  // through reset as well.
  assign Qn = ~q_q;

endmodule

// File: tb/tb_alu_ffec32.sv
// tb_alu_ffec32 -- directed self-checking bench for alu_ffec32.
//
// The bench drives hand-computed vectors through the ALU and the register.
// It checks the ALU results, the zero flag, reset behaviour, loads from D and
// from R, holding the value, and asynchronous clear.
module tb_alu_ffec32;

  logic        Clk;
  logic        Clrn;
  logic [31:0] X;
  logic [31:0] Y;
  logic [1:0]  Aluc;
  logic [31:0] D;
  logic        Sel;
  logic        En;
  logic [31:0] R;
  logic        Z;
  logic [31:0] Q;
  logic [31:0] Qn;

  int checks = 0;
  int errors = 0;

  alu_ffec32 #(.WIDTH(32)) dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .X    (X),
    .Y    (Y),
    .Aluc (Aluc),
    .D    (D),
    .Sel  (Sel),
    .En   (En),
    .R    (R),
    .Z    (Z),
    .Q    (Q),
    .Qn   (Qn)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_r, input logic exp_z);
    X = a;
    Y = b;
    Aluc = op;
    #1;
    check({tag, "_R"}, R, exp_r);
    check({tag, "_Z"}, {31'b0, Z}, {31'b0, exp_z});
  endtask

  initial begin
    Clrn = 1'b0;
    X    = 32'h0000_000C;
    Y    = 32'h0000_000A;
    Aluc = 2'b10;
    D    = 32'h0000_0666;
    Sel  = 1'b1;
    En   = 1'b1;

    // Reset held across several edges with a load requested: reset wins.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_Q", Q, 32'h0000_0000);
    check("rst_Qn", Qn, 32'hFFFF_FFFF);

    // ALU operations (checked while reset is held: R and Z are unaffected).
    alu_vec("and", 32'h0000_000C, 32'h0000_000A, 2'b10, 32'h0000_0008, 1'b0);
    alu_vec("add", 32'h0000_000C, 32'h0000_000A, 2'b00, 32'h0000_0016, 1'b0);
    alu_vec("sub", 32'h0000_000C, 32'h0000_000A, 2'b01, 32'h0000_0002, 1'b0);
    alu_vec("or", 32'h0000_000C, 32'h0000_000A, 2'b11, 32'h0000_000E, 1'b0);
    alu_vec("sub_eq", 32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 1'b1);
    alu_vec("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 1'b1);
    alu_vec("sub_wrap", 32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 1'b0);
    alu_vec("and_zero", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 32'h0000_0000, 1'b1);
    alu_vec("or_mix", 32'hF0F0_0000, 32'h0000_0F0F, 2'b11, 32'hF0F0_0F0F, 1'b0);
    alu_vec("add_big", 32'h8000_0001, 32'h7FFF_FFFF, 2'b00, 32'h0000_0000, 1'b1);
    alu_vec("sub_big", 32'h1234_5678, 32'h0000_0678, 2'b01, 32'h1234_5000, 1'b0);
    check("rst_Q_after_alu", Q, 32'h0000_0000);

    // Release reset mid-cycle; Q must not change until the next rising edge.
    Clrn = 1'b1;
    #1;
    check("rel_Q_noedge", Q, 32'h0000_0000);
    @(negedge Clk);
    check("load_D_Q", Q, 32'h0000_0666);
    check("load_D_Qn", Qn, 32'hFFFF_F999);

    // Asynchronous clear with no clock edge.
    #2;
    Clrn = 1'b0;
    #1;
    check("aclr_Q", Q, 32'h0000_0000);
    check("aclr_Qn", Qn, 32'hFFFF_FFFF);

    // After release with En low, the edge must not load anything.
    En = 1'b0;
    #1;
    Clrn = 1'b1;
    @(negedge Clk);
    check("rel_en0_Q", Q, 32'h0000_0000);

    // Load from the ALU: 0xC + 0xA.
    Sel  = 1'b0;
    En   = 1'b1;
    X    = 32'h0000_000C;
    Y    = 32'h0000_000A;
    Aluc = 2'b00;
    @(negedge Clk);
    check("load_R_Q", Q, 32'h0000_0016);
    check("load_R_Qn", Qn, 32'hFFFF_FFE9);

    // Hold with En low while X, D and Sel change between edges.
    En = 1'b0;
    X  = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      #2;
      D   = 32'hDEAD_0000 + 32'(i);
      Sel = ~Sel;
      @(negedge Clk);
      check("hold_Q", Q, 32'h0000_0016);
    end

    // Changes between edges with En high do not affect Q until the edge.
    Sel = 1'b1;
    D   = 32'hCAFE_BABE;
    En  = 1'b1;
    #1;
    check("midcycle_Q", Q, 32'h0000_0016);
    @(negedge Clk);
    check("load_D2_Q", Q, 32'hCAFE_BABE);
    check("load_D2_Qn", Qn, 32'h3501_4541);

    // Load the ALU result of a subtract that wraps.
    Sel  = 1'b0;
    X    = 32'h0000_0000;
    Y    = 32'h0000_0001;
    Aluc = 2'b01;
    @(negedge Clk);
    check("load_sub_Q", Q, 32'hFFFF_FFFF);
    check("load_sub_Qn", Qn, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
